// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and shared memory-port signals of mem_port_arbiter.
// The arbiter takes the slave view; the pipeline/memory-bridge side takes the master view.
interface mem_port_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [1:0]  inst_size;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_req, inst_addr, inst_size,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output inst_req, inst_addr, inst_size,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one in-order SRAM-like port between instruction fetch and MEM-stage load/store,
// data-first with a starvation limit, routing responses back through an owner-ID FIFO.
module mem_port_arbiter #(
    parameter int MAX_OUTST  = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    mem_port_arbiter_if.slave            bus,
    output logic [$clog2(MAX_OUTST):0]   outst_cnt,
    output logic                         err_unexp,
    output logic [$clog2(STARVE_MAX+1)-1:0] starve_cnt
);
    localparam int PW = $clog2(MAX_OUTST);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    // Handshake: a request transfers in the cycle req and addr_ok are both high;
    // requesters hold req and fields stable until then. data_ok is a one-cycle
    // response strobe with no back-pressure.

    logic [MAX_OUTST-1:0] owner_q;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;

    logic full;
    logic empty;
    logic force_inst;
    logic gnt_data;
    logic gnt_inst;
    logic push;
    logic pop;
    logic pop_owner;

    assign full       = (outst_cnt == CW'(MAX_OUTST));
    assign empty      = (outst_cnt == '0);
    assign force_inst = bus.inst_req & (starve_cnt == SW'(STARVE_MAX));
    assign gnt_data   = bus.data_req & ~force_inst;
    assign gnt_inst   = bus.inst_req & ~gnt_data;

    assign bus.mem_req = (gnt_data | gnt_inst) & ~full;
    assign push        = bus.mem_req & bus.mem_addr_ok;

    assign bus.data_addr_ok = push & gnt_data;
    assign bus.inst_addr_ok = push & gnt_inst;

    always_comb begin
        bus.mem_wr    = 1'b0;
        bus.mem_size  = 2'd0;
        bus.mem_wstrb = 4'd0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        if (gnt_data) begin
            bus.mem_wr    = bus.data_wr;
            bus.mem_size  = bus.data_size;
            bus.mem_wstrb = bus.data_wstrb;
            bus.mem_addr  = bus.data_addr;
            bus.mem_wdata = bus.data_wdata;
        end else if (gnt_inst) begin
            bus.mem_size  = bus.inst_size;
            bus.mem_addr  = bus.inst_addr;
        end
    end

    // Responses arrive in request order, so the FIFO head names their owner.
    assign pop       = bus.mem_data_ok & ~empty;
    assign pop_owner = owner_q[rd_ptr];

    assign bus.data_data_ok = pop & pop_owner;
    assign bus.inst_data_ok = pop & ~pop_owner;
    assign bus.data_rdata   = bus.data_data_ok ? bus.mem_rdata : 32'd0;
    assign bus.inst_rdata   = bus.inst_data_ok ? bus.mem_rdata : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            outst_cnt  <= '0;
            err_unexp  <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (push) begin
                owner_q[wr_ptr] <= gnt_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   outst_cnt <= outst_cnt + 1'b1;
                2'b01:   outst_cnt <= outst_cnt - 1'b1;
                default: outst_cnt <= outst_cnt;
            endcase

            if (bus.mem_data_ok && empty) begin
                err_unexp <= 1'b1;
            end

            // Counts data wins against a waiting fetch; any fetch win or idle fetch resets it.
            if (!bus.inst_req || bus.inst_addr_ok) begin
                starve_cnt <= '0;
            end else if (bus.data_addr_ok && (starve_cnt != SW'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
endmodule
